// File: rtl/triangle_span_scanner_if.sv
// rtl/triangle_span_scanner_if.sv - vertex input, tester handshake and SRAM write bus of the span scanner.
// master is the scanner side, slave is the vertex source / tester / SRAM side.
interface triangle_span_scanner_if #(
  parameter int COORD_W = 11,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 31
);
  logic               start;
  logic [COORD_W-1:0] ax, ay, bx, by, cx, cy;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               in_triangle;
  logic [ADDR_W-1:0]  sram_addr;
  logic [DATA_W-1:0]  sram_data;
  logic               sram_we_n;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  rows_written;

  modport master (
    input  start, ax, ay, bx, by, cx, cy, in_triangle,
    output scan_x, scan_y, sram_addr, sram_data, sram_we_n, sram_ce_n, sram_oe_n,
           busy, done, rows_written
  );

  modport slave (
    output start, ax, ay, bx, by, cx, cy, in_triangle,
    input  scan_x, scan_y, sram_addr, sram_data, sram_we_n, sram_ce_n, sram_oe_n,
           busy, done, rows_written
  );
endinterface

// File: rtl/triangle_span_scanner.sv
// rtl/triangle_span_scanner.sv - raster-scans a triangle's clamped bounding box one pixel per clock.
// Each row with inside pixels yields one {y, right, left} word written to SRAM with a three-cycle write.
module triangle_span_scanner #(
  parameter int COORD_W = 11,
  parameter int X_LAST  = 1505,
  parameter int Y_LAST  = 480,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 31
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  triangle_span_scanner_if.master bus
);
  localparam int                 ROW_Y_W  = DATA_W - 2 * COORD_W;
  localparam logic [COORD_W-1:0] XL       = COORD_W'(X_LAST);
  localparam logic [COORD_W-1:0] YL       = COORD_W'(Y_LAST);
  localparam logic [ADDR_W-1:0]  ROWS_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_BBOX, S_SCAN, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_NEXT_ROW, S_FINISH
  } state_t;

  state_t             r_state;
  logic [COORD_W-1:0] r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymax;
  logic [COORD_W-1:0] r_scan_x, r_scan_y;
  logic [COORD_W-1:0] r_left, r_right;
  logic               r_row_flag;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_we_n, r_ce_n;
  logic               r_busy, r_done;
  logic [ADDR_W-1:0]  r_rows;

  logic [COORD_W-1:0] w_xmin, w_xmax_raw, w_xmax, w_ymin, w_ymax_raw, w_ymax;
  logic [COORD_W-1:0] w_ab_xmin, w_ab_xmax, w_ab_ymin, w_ab_ymax;
  logic               w_box_empty;
  logic               w_row_end;
  logic               w_flag_nxt;
  logic [COORD_W-1:0] w_left_nxt, w_right_nxt;

  assign w_ab_xmin   = (r_ax < r_bx) ? r_ax : r_bx;
  assign w_ab_xmax   = (r_ax > r_bx) ? r_ax : r_bx;
  assign w_ab_ymin   = (r_ay < r_by) ? r_ay : r_by;
  assign w_ab_ymax   = (r_ay > r_by) ? r_ay : r_by;
  assign w_xmin      = (w_ab_xmin < r_cx) ? w_ab_xmin : r_cx;
  assign w_xmax_raw  = (w_ab_xmax > r_cx) ? w_ab_xmax : r_cx;
  assign w_ymin      = (w_ab_ymin < r_cy) ? w_ab_ymin : r_cy;
  assign w_ymax_raw  = (w_ab_ymax > r_cy) ? w_ab_ymax : r_cy;
  assign w_xmax      = (w_xmax_raw > XL) ? XL : w_xmax_raw;
  assign w_ymax      = (w_ymax_raw > YL) ? YL : w_ymax_raw;
  assign w_box_empty = (w_xmin > XL) || (w_ymin > YL);

  // Span bounds as they will stand after the current pixel, so the last
  // pixel of a row can both open/extend the span and feed the write word.
  assign w_row_end   = (r_scan_x == r_xmax);
  assign w_flag_nxt  = r_row_flag | bus.in_triangle;
  assign w_left_nxt  = (bus.in_triangle && !r_row_flag) ? r_scan_x : r_left;
  assign w_right_nxt = bus.in_triangle ? r_scan_x : r_right;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_ax       <= '0;
      r_ay       <= '0;
      r_bx       <= '0;
      r_by       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_scan_x   <= '0;
      r_scan_y   <= '0;
      r_left     <= '0;
      r_right    <= '0;
      r_row_flag <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we_n     <= 1'b1;
      r_ce_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rows     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ax    <= bus.ax;
            r_ay    <= bus.ay;
            r_bx    <= bus.bx;
            r_by    <= bus.by;
            r_cx    <= bus.cx;
            r_cy    <= bus.cy;
            r_busy  <= 1'b1;
            r_rows  <= '0;
            r_state <= S_BBOX;
          end
        end
        S_BBOX: begin
          if (w_box_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_xmin     <= w_xmin;
            r_xmax     <= w_xmax;
            r_ymax     <= w_ymax;
            r_scan_x   <= w_xmin;
            r_scan_y   <= w_ymin;
            r_row_flag <= 1'b0;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_left     <= w_left_nxt;
          r_right    <= w_right_nxt;
          r_row_flag <= w_flag_nxt;
          if (w_row_end) begin
            if (w_flag_nxt) begin
              r_addr  <= r_rows;
              r_data  <= {r_scan_y[ROW_Y_W-1:0], w_right_nxt, w_left_nxt};
              r_ce_n  <= 1'b0;
              r_we_n  <= 1'b1;
              r_state <= S_W_SETUP;
            end else begin
              r_state <= S_NEXT_ROW;
            end
          end else begin
            r_scan_x <= r_scan_x + 1'b1;
          end
        end
        S_W_SETUP: begin
          r_we_n  <= 1'b0;
          r_state <= S_W_PULSE;
        end
        S_W_PULSE: begin
          r_we_n <= 1'b1;
          if (r_rows != ROWS_MAX) begin
            r_rows <= r_rows + 1'b1;
          end
          r_state <= S_W_HOLD;
        end
        S_W_HOLD: begin
          r_ce_n     <= 1'b1;
          r_row_flag <= 1'b0;
          r_state    <= S_NEXT_ROW;
        end
        S_NEXT_ROW: begin
          r_ce_n     <= 1'b1;
          r_row_flag <= 1'b0;
          if (r_scan_y == r_ymax) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_scan_y <= r_scan_y + 1'b1;
            r_scan_x <= r_xmin;
            r_state  <= S_SCAN;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.scan_x       = r_scan_x;
  assign bus.scan_y       = r_scan_y;
  assign bus.sram_addr    = r_addr;
  assign bus.sram_data    = r_data;
  assign bus.sram_we_n    = r_we_n;
  assign bus.sram_ce_n    = r_ce_n;
  assign bus.sram_oe_n    = 1'b1;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.rows_written = r_rows;
endmodule
